// File: rtl/spi_slave_sync.sv
// spi_slave_sync
//   SPI slave that runs entirely in the clk domain. cs, spi_clk and mosi are
//   oversampled through SYNC_STAGES flops; spi_clk edges are found by comparing
//   the newest synchronised sample with the one before it. All four SPI modes
//   and any word width from 2 to 32 are supported. Frames may carry any number
//   of back-to-back words while cs is low; a partial word is dropped on cs rise.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   cs          chip select, active low, asynchronous
//   spi_clk     SPI clock, asynchronous, at most clk/8
//   mosi        master-out data, asynchronous
//   miso        slave-out data (registered)
//   miso_oe     high while selected; enables the external tristate
//   tx_data     next word to transmit
//   tx_valid    tx_data valid; accepted when tx_ready is high
//   tx_ready    TX holding register empty
//   rx_data     last complete received word, held until the next rx_valid
//   rx_valid    one-cycle pulse, rx_data updated
//   tx_underrun one-cycle pulse, FILL was loaded because holding was empty
//   busy        high while a frame is active
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_IDLE | after reset; waits for cs high so a frame is never joined
//           | part-way through
// IDLE      | deselected; a cs falling edge starts a frame
// ACTIVE    | selected; shifting words, any cs high ends the frame

module spi_slave_sync #(
  parameter int                WORD_W      = 8,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                MSB_FIRST   = 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] FILL        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              spi_clk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int          CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic        SCLK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_nx;

  // Synchronisers. cs resets to 0 so that a reset taken mid-frame keeps the
  // FSM in WAIT_IDLE until cs is genuinely seen high.
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_d, sclk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '0;
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= SCLK_IDLE;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic cs_fall, sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic selected, sample_edge, drive_edge, word_done, load;

  assign cs_fall    = cs_d & ~cs_s;
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign lead_edge  = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge = (CPOL != 0) ? sclk_rise : sclk_fall;

  // cs high masks any spi_clk edge seen in the same cycle.
  assign selected    = (state == ACTIVE) & ~cs_s;
  assign sample_edge = selected & ((CPHA != 0) ? trail_edge : lead_edge);
  assign drive_edge  = selected & ((CPHA != 0) ? lead_edge : trail_edge);

  logic [CNT_W-1:0] bit_cnt;

  assign word_done = sample_edge & (bit_cnt == LAST_BIT);
  assign load      = ((state == IDLE) & cs_fall) | word_done;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_IDLE: if (cs_s)    state_nx = IDLE;
      IDLE:      if (cs_fall) state_nx = ACTIVE;
      ACTIVE:    if (cs_s)    state_nx = IDLE;
      default:                state_nx = WAIT_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state == ACTIVE);
    miso_oe = (state == ACTIVE);
  end

  function automatic logic first_bit(input logic [WORD_W-1:0] v);
    return (MSB_FIRST != 0) ? v[WORD_W-1] : v[0];
  endfunction

  function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[WORD_W-2:0], 1'b0} : {1'b0, v[WORD_W-1:1]};
  endfunction

  logic [WORD_W-1:0] hold, tx_sh, rx_sh, rx_next, load_word;
  logic              hold_full;

  assign rx_next   = (MSB_FIRST != 0) ? {rx_sh[WORD_W-2:0], mosi_s}
                                      : {mosi_s, rx_sh[WORD_W-1:1]};
  assign load_word = hold_full ? hold : FILL;
  assign tx_ready  = ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      // Deselected or leaving the frame: drop the partial word, park miso.
      if (state != ACTIVE || cs_s) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end

      if (sample_edge) begin
        rx_sh <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      // With CPHA=0 the first bit of a word is already on miso from the load,
      // so the trailing edge that directly follows a word boundary must not
      // shift again.
      if (drive_edge && ((CPHA != 0) || (bit_cnt != '0))) begin
        miso  <= first_bit(tx_sh);
        tx_sh <= shift_out(tx_sh);
      end

      if (load) begin
        if (hold_full) hold_full   <= 1'b0;
        else           tx_underrun <= 1'b1;
        if (CPHA == 0) begin
          miso  <= first_bit(load_word);
          tx_sh <= shift_out(load_word);
        end else begin
          tx_sh <= load_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four WORD_W=8 MSB-first instances (modes 0..3)
// and one WORD_W=16 LSB-first mode-0 instance, driven by a behavioural SPI
// master. Expected words come from what the bench pushed/sent.

module tb_spi_slave_sync;

  localparam int HP = 8;  // spi_clk half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cs [5];
  logic       sclk [5];
  logic       mosi [5];
  logic       txv [5];
  logic       miso [5];
  logic       oe [5];
  logic       txr [5];
  logic       rxv [5];
  logic       und [5];
  logic       busy [5];
  logic [7:0] td8 [4];
  logic [7:0] rd8 [4];
  logic [15:0] td16, rd16;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_sync #(
      .WORD_W(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1),
      .SYNC_STAGES(2), .FILL(8'h00)
    ) u_dut (
      .clk(clk), .rst(rst), .cs(cs[g]), .spi_clk(sclk[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(oe[g]), .tx_data(td8[g]), .tx_valid(txv[g]),
      .tx_ready(txr[g]), .rx_data(rd8[g]), .rx_valid(rxv[g]),
      .tx_underrun(und[g]), .busy(busy[g])
    );
  end

  spi_slave_sync #(
    .WORD_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0),
    .SYNC_STAGES(2), .FILL(16'h0000)
  ) u_dut16 (
    .clk(clk), .rst(rst), .cs(cs[4]), .spi_clk(sclk[4]), .mosi(mosi[4]),
    .miso(miso[4]), .miso_oe(oe[4]), .tx_data(td16), .tx_valid(txv[4]),
    .tx_ready(txr[4]), .rx_data(rd16), .rx_valid(rxv[4]),
    .tx_underrun(und[4]), .busy(busy[4])
  );

  int rxcnt [5] = '{default: 0};
  int undcnt [5] = '{default: 0};

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (rxv[k] === 1'b1) rxcnt[k] <= rxcnt[k] + 1;
      if (und[k] === 1'b1) undcnt[k] <= undcnt[k] + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] rdv(input int k);
    if (k == 4) return rd16;
    return {8'h00, rd8[k]};
  endfunction

  task automatic push(input int k, input logic [15:0] v);
    int n = 0;
    @(negedge clk);
    while (txr[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("push_wait_%0d", k), 32'(n < 100), 32'd1);
    if (k == 4) td16 = v;
    else        td8[k] = v[7:0];
    txv[k] = 1'b1;
    @(negedge clk);
    txv[k] = 1'b0;
  endtask

  task automatic frame_begin(input int k);
    cs[k] = 1'b0;
    wait_cyc(HP);
  endtask

  task automatic frame_end(input int k);
    wait_cyc(HP);
    cs[k] = 1'b1;
    wait_cyc(2 * HP);
  endtask

  // Behavioural master: clocks nbits of mo out on mosi and returns what it
  // sampled from miso, assembled in the same bit order as the instance.
  task automatic xfer(input int k, input logic [15:0] mo, input int nbits,
                      output logic [15:0] mi);
    int   w    = (k == 4) ? 16 : 8;
    bit   msb  = (k != 4);
    logic cpol = (k < 4) ? logic'((k / 2) % 2) : 1'b0;
    logic cpha = (k < 4) ? logic'(k % 2) : 1'b0;
    int   idx;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (w - 1 - i) : i;
      if (!cpha) begin
        mosi[k] = mo[idx];
        wait_cyc(HP);
        mi[idx] = miso[k];
        sclk[k] = ~cpol;
        wait_cyc(HP);
        sclk[k] = cpol;
      end else begin
        sclk[k] = ~cpol;
        mosi[k] = mo[idx];
        wait_cyc(HP);
        mi[idx] = miso[k];
        sclk[k] = cpol;
        wait_cyc(HP);
      end
    end
  endtask

  initial begin
    logic [15:0] mi, mi1, mi2, mi3, t, m, w1, w3, w4;
    int c0, u0;

    for (int k = 0; k < 5; k++) begin
      cs[k]   = 1'b1;
      sclk[k] = (k < 4) ? logic'((k / 2) % 2) : 1'b0;
      mosi[k] = 1'b0;
      txv[k]  = 1'b0;
    end
    for (int k = 0; k < 4; k++) td8[k] = '0;
    td16 = '0;

    rst = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(1);
    check("rst_miso", 32'(miso[0]), 32'd0);
    check("rst_oe", 32'(oe[0]), 32'd0);
    check("rst_tx_ready", 32'(txr[0]), 32'd1);
    check("rst_rx_data", 32'(rd8[0]), 32'd0);
    check("rst_rx_valid", 32'(rxv[0]), 32'd0);
    check("rst_underrun", 32'(und[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rx_data16", 32'(rd16), 32'd0);
    wait_cyc(2 * HP);

    // Mode 0 directed exchange
    push(0, 16'h00A5);
    check("m0_hold_full", 32'(txr[0]), 32'd0);
    frame_begin(0);
    check("m0_oe_active", 32'(oe[0]), 32'd1);
    check("m0_busy_active", 32'(busy[0]), 32'd1);
    c0 = rxcnt[0];
    u0 = undcnt[0];
    xfer(0, 16'h003C, 8, mi);
    check("m0_miso_word", 32'(mi), 32'h00A5);
    check("m0_rx_data", 32'(rdv(0)), 32'h003C);
    check("m0_rx_valid_cnt", 32'(rxcnt[0] - c0), 32'd1);
    // The word boundary after the only word reloads from an empty holding
    check("m0_underrun_cnt", 32'(undcnt[0] - u0), 32'd1);
    frame_end(0);
    check("m0_oe_idle", 32'(oe[0]), 32'd0);
    check("m0_miso_idle", 32'(miso[0]), 32'd0);
    check("m0_busy_idle", 32'(busy[0]), 32'd0);
    check("m0_tx_ready_idle", 32'(txr[0]), 32'd1);

    // Modes 1..3: directed pair then random pairs
    for (int k = 1; k < 4; k++) begin
      for (int r = 0; r < 3; r++) begin
        t = (r == 0) ? 16'h005A : 16'($urandom_range(0, 255));
        m = (r == 0) ? 16'h00C3 : 16'($urandom_range(0, 255));
        push(k, t);
        frame_begin(k);
        c0 = rxcnt[k];
        xfer(k, m, 8, mi);
        check($sformatf("mode%0d_miso_%0d", k, r), 32'(mi), 32'(t));
        check($sformatf("mode%0d_rx_%0d", k, r), 32'(rdv(k)), 32'(m));
        check($sformatf("mode%0d_rxcnt_%0d", k, r), 32'(rxcnt[k] - c0), 32'd1);
        frame_end(k);
      end
    end

    // Three-word frame, holding refilled for words 1 and 3 only
    w1 = 16'($urandom_range(0, 255));
    w3 = 16'($urandom_range(0, 255));
    w4 = 16'($urandom_range(0, 255));
    push(0, w1);
    frame_begin(0);
    c0 = rxcnt[0];
    u0 = undcnt[0];
    m = 16'($urandom_range(0, 255));
    xfer(0, m, 8, mi1);
    check("mw_rx_w1", 32'(rdv(0)), 32'(m));
    push(0, w3);
    m = 16'($urandom_range(0, 255));
    xfer(0, m, 8, mi2);
    check("mw_rx_w2", 32'(rdv(0)), 32'(m));
    push(0, w4);  // keeps the load after word 3 from underrunning
    m = 16'($urandom_range(0, 255));
    xfer(0, m, 8, mi3);
    check("mw_rx_w3", 32'(rdv(0)), 32'(m));
    frame_end(0);
    check("mw_miso_w1", 32'(mi1), 32'(w1));
    check("mw_miso_w2_fill", 32'(mi2), 32'h0000);
    check("mw_miso_w3", 32'(mi3), 32'(w3));
    check("mw_rxcnt", 32'(rxcnt[0] - c0), 32'd3);
    check("mw_underrun_cnt", 32'(undcnt[0] - u0), 32'd1);

    // Abort after 5 bits; holding loaded during the frame must survive
    frame_begin(0);
    push(0, 16'h0099);
    c0 = rxcnt[0];
    xfer(0, 16'h00FF, 5, mi);
    check("abort_partial_fill", 32'(mi), 32'h0000);
    frame_end(0);
    check("abort_no_rx_valid", 32'(rxcnt[0] - c0), 32'd0);
    check("abort_hold_kept", 32'(txr[0]), 32'd0);
    frame_begin(0);
    xfer(0, 16'h0081, 8, mi);
    check("abort_next_rx", 32'(rdv(0)), 32'h0081);
    check("abort_next_miso", 32'(mi), 32'h0099);
    check("abort_next_rxcnt", 32'(rxcnt[0] - c0), 32'd1);
    frame_end(0);

    // Reset mid-word with cs held low
    push(0, 16'h003C);
    frame_begin(0);
    xfer(0, 16'h00AA, 3, mi);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("rstmid_miso", 32'(miso[0]), 32'd0);
    check("rstmid_oe", 32'(oe[0]), 32'd0);
    check("rstmid_busy", 32'(busy[0]), 32'd0);
    check("rstmid_tx_ready", 32'(txr[0]), 32'd1);
    check("rstmid_rx_data", 32'(rd8[0]), 32'd0);
    c0 = rxcnt[0];
    xfer(0, 16'($urandom_range(0, 255)), 8, mi);
    check("rstmid_no_rx", 32'(rxcnt[0] - c0), 32'd0);
    check("rstmid_still_idle", 32'(busy[0]), 32'd0);
    frame_end(0);
    push(0, 16'h007E);
    frame_begin(0);
    xfer(0, 16'h00E7, 8, mi);
    check("rstmid_after_rx", 32'(rdv(0)), 32'h00E7);
    check("rstmid_after_miso", 32'(mi), 32'h007E);
    check("rstmid_after_rxcnt", 32'(rxcnt[0] - c0), 32'd1);
    frame_end(0);

    // 16-bit LSB-first instance
    for (int r = 0; r < 3; r++) begin
      t = 16'($urandom_range(0, 65535));
      m = (r == 0) ? 16'h1234 : 16'($urandom_range(0, 65535));
      push(4, t);
      frame_begin(4);
      c0 = rxcnt[4];
      xfer(4, m, 16, mi);
      check($sformatf("w16_first_bit_%0d", r), 32'(mi[0]), 32'(t[0]));
      check($sformatf("w16_miso_%0d", r), 32'(mi), 32'(t));
      check($sformatf("w16_rx_%0d", r), 32'(rdv(4)), 32'(m));
      check($sformatf("w16_rxcnt_%0d", r), 32'(rxcnt[4] - c0), 32'd1);
      frame_end(4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
